// File: rtl/datapath_sequencer_if.sv
// Handshake and strobe bundle between a controller and datapath_sequencer.
// Optional: SEQ_ABORT_EN adds the abort request line.
interface datapath_sequencer_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic [CNT_W-1:0] iter;
  logic             busy;
  logic             done;
  logic             RAin;
  logic             RBin;
  logic             RZin;
  logic             RAout;
  logic             RBout;
  logic             RZout;
`ifdef SEQ_ABORT_EN
  logic             abort;
`endif

  // Controller side: issues requests, observes strobes
  modport master (
`ifdef SEQ_ABORT_EN
    output abort,
`endif
    output start, iter,
    input  busy, done, RAin, RBin, RZin, RAout, RBout, RZout
  );

  // Sequencer side: accepts requests, drives strobes
  modport slave (
`ifdef SEQ_ABORT_EN
    input  abort,
`endif
    input  start, iter,
    output busy, done, RAin, RBin, RZin, RAout, RBout, RZout
  );
endinterface

// File: rtl/datapath_sequencer.sv
// Moore control FSM for the 8-bit RA/RB/RZ tutorial datapath.
// Runs: RA <- imm; RB <- RA; then iter x (RZ <- A + RB; RB <- RZ).
// Optional: define SEQ_ABORT_EN to add an abort input that returns to IDLE.
module datapath_sequencer #(
  parameter int CNT_W = 4
) (
  input  logic                 clock,
  input  logic                 clear,
  datapath_sequencer_if.slave  sif
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOADA, S_XFER, S_ADD, S_WB, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_dec;
  logic             abort_w;

`ifdef SEQ_ABORT_EN
  assign abort_w = sif.abort;
`else
  assign abort_w = 1'b0;
`endif

  // Only evaluated in WB, where cnt_q is guaranteed nonzero, so no wrap
  assign cnt_dec = cnt_q - CNT_W'(1);

  // State and iteration counter registers
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter update; abort overrides every other transition
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (sif.start && !abort_w) begin
          state_d = S_LOADA;
          cnt_d   = sif.iter;
        end
      end
      S_LOADA: state_d = S_XFER;
      S_XFER:  state_d = (cnt_q != '0) ? S_ADD : S_DONE;
      S_ADD:   state_d = S_WB;
      S_WB: begin
        cnt_d   = cnt_dec;
        state_d = (cnt_dec != '0) ? S_ADD : S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_w && state_q != S_IDLE) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // Moore output decode: strobes depend on state only, one bus driver max
  always_comb begin
    sif.busy  = (state_q != S_IDLE);
    sif.done  = 1'b0;
    sif.RAin  = 1'b0;
    sif.RBin  = 1'b0;
    sif.RZin  = 1'b0;
    sif.RAout = 1'b0;
    sif.RBout = 1'b0;
    sif.RZout = 1'b0;
    case (state_q)
      S_LOADA: sif.RAin = 1'b1;
      S_XFER: begin
        sif.RAout = 1'b1;
        sif.RBin  = 1'b1;
      end
      S_ADD: begin
        sif.RBout = 1'b1;
        sif.RZin  = 1'b1;
      end
      S_WB: begin
        sif.RZout = 1'b1;
        sif.RBin  = 1'b1;
      end
      S_DONE:  sif.done = 1'b1;
      default: ;
    endcase
  end

endmodule
